pipeline_hazard_unit: RTL and testbench

//  Hazard control for the 5-stage pipeline (IF/ID/EX/MEM/WB). Keeps a registered

---
 rtl/pipeline_defs.sv | 20 ++
 rtl/hazard_match.sv | 17 +
 rtl/pipeline_hazard_unit.sv | 160 ++++++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_defs.sv
// rtl/pipeline_defs.sv - shared forwarding codes, zero-register index and scoreboard slot flag layout
package pipeline_defs;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam int REG_ZERO = 0;

    // Per-slot control flags; register addresses are appended by the user
    // because their width is a module parameter.
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic uses_rs;
        logic uses_rt;
    } slot_flags_t;

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - combinational compare of one scoreboard slot against one register address
module hazard_match
    import pipeline_defs::*;
#(
    parameter int REG_ADDR_BITS = 5
) (
    input  logic                     valid,
    input  logic                     reg_write,
    input  logic [REG_ADDR_BITS-1:0] w_addr,
    input  logic [REG_ADDR_BITS-1:0] r,
    output logic                     hit
);

    // Register zero is hardwired, so a write to it never creates a dependency.
    assign hit = valid & reg_write & (w_addr == r) & (r != REG_ADDR_BITS'(REG_ZERO));

endmodule

// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - load-use stall, branch flush and EX forwarding control; HAZARD_FORWARD_EN enables forwarding
module pipeline_hazard_unit
    import pipeline_defs::*;
#(
    parameter int REG_ADDR_BITS = 5,
    parameter int CNT_WIDTH     = 16,
    parameter int RF_BYPASS     = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     id_valid,
    input  logic [REG_ADDR_BITS-1:0] id_rs_addr,
    input  logic [REG_ADDR_BITS-1:0] id_rt_addr,
    input  logic                     id_uses_rs,
    input  logic                     id_uses_rt,
    input  logic                     id_reg_write,
    input  logic                     id_mem_read,
    input  logic [REG_ADDR_BITS-1:0] id_w_addr,
    input  logic                     branch_taken,
    output logic                     pc_hold,
    output logic                     ifid_hold,
    output logic                     idex_bubble,
    output logic                     flush_ifid,
    output logic                     flush_idex,
    output logic                     flush_exmem,
    output logic [1:0]               fwd_a,
    output logic [1:0]               fwd_b,
    output logic [CNT_WIDTH-1:0]     stall_count,
    output logic [CNT_WIDTH-1:0]     flush_count
);

    typedef struct packed {
        slot_flags_t              f;
        logic [REG_ADDR_BITS-1:0] w_addr;
        logic [REG_ADDR_BITS-1:0] rs;
        logic [REG_ADDR_BITS-1:0] rt;
    } slot_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    slot_t ex_q, mem_q, wb_q, id_slot;
    logic  id_rs_ex, id_rs_mem, id_rs_wb;
    logic  id_rt_ex, id_rt_mem, id_rt_wb;
    logic  h_rs, h_rt, hz, stall;

    // Pack the ID-stage instruction into the slot layout it will occupy in EX.
    always_comb begin
        id_slot             = '0;
        id_slot.f.valid     = id_valid;
        id_slot.f.reg_write = id_reg_write;
        id_slot.f.mem_read  = id_mem_read;
        id_slot.f.uses_rs   = id_uses_rs;
        id_slot.f.uses_rt   = id_uses_rt;
        id_slot.w_addr      = id_w_addr;
        id_slot.rs          = id_rs_addr;
        id_slot.rt          = id_rt_addr;
    end

    hazard_match #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_rs_ex (
        .valid(ex_q.f.valid), .reg_write(ex_q.f.reg_write), .w_addr(ex_q.w_addr),
        .r(id_rs_addr), .hit(id_rs_ex));
    hazard_match #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_rs_mem (
        .valid(mem_q.f.valid), .reg_write(mem_q.f.reg_write), .w_addr(mem_q.w_addr),
        .r(id_rs_addr), .hit(id_rs_mem));
    hazard_match #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_rs_wb (
        .valid(wb_q.f.valid), .reg_write(wb_q.f.reg_write), .w_addr(wb_q.w_addr),
        .r(id_rs_addr), .hit(id_rs_wb));
    hazard_match #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_rt_ex (
        .valid(ex_q.f.valid), .reg_write(ex_q.f.reg_write), .w_addr(ex_q.w_addr),
        .r(id_rt_addr), .hit(id_rt_ex));
    hazard_match #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_rt_mem (
        .valid(mem_q.f.valid), .reg_write(mem_q.f.reg_write), .w_addr(mem_q.w_addr),
        .r(id_rt_addr), .hit(id_rt_mem));
    hazard_match #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_rt_wb (
        .valid(wb_q.f.valid), .reg_write(wb_q.f.reg_write), .w_addr(wb_q.w_addr),
        .r(id_rt_addr), .hit(id_rt_wb));

`ifdef HAZARD_FORWARD_EN
    logic ex_rs_mem, ex_rs_wb, ex_rt_mem, ex_rt_wb;

    // With forwarding only a load still in EX cannot supply its result in time.
    assign h_rs = id_rs_ex & ex_q.f.mem_read;
    assign h_rt = id_rt_ex & ex_q.f.mem_read;

    hazard_match #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_exrs_mem (
        .valid(mem_q.f.valid), .reg_write(mem_q.f.reg_write), .w_addr(mem_q.w_addr),
        .r(ex_q.rs), .hit(ex_rs_mem));
    hazard_match #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_exrs_wb (
        .valid(wb_q.f.valid), .reg_write(wb_q.f.reg_write), .w_addr(wb_q.w_addr),
        .r(ex_q.rs), .hit(ex_rs_wb));
    hazard_match #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_exrt_mem (
        .valid(mem_q.f.valid), .reg_write(mem_q.f.reg_write), .w_addr(mem_q.w_addr),
        .r(ex_q.rt), .hit(ex_rt_mem));
    hazard_match #(.REG_ADDR_BITS(REG_ADDR_BITS)) u_exrt_wb (
        .valid(wb_q.f.valid), .reg_write(wb_q.f.reg_write), .w_addr(wb_q.w_addr),
        .r(ex_q.rt), .hit(ex_rt_wb));

    // EX operand select; the younger producer in EX/MEM wins over MEM/WB.
    always_comb begin
        fwd_a = FWD_IDEX;
        fwd_b = FWD_IDEX;
        if (ex_rs_mem & ex_q.f.uses_rs)
            fwd_a = FWD_EXMEM;
        else if (ex_rs_wb)
            fwd_a = FWD_MEMWB;
        if (ex_rt_mem & ex_q.f.uses_rt)
            fwd_b = FWD_EXMEM;
        else if (ex_rt_wb)
            fwd_b = FWD_MEMWB;
    end
`else
    // No forwarding paths: any in-flight producer must retire before the read.
    assign h_rs  = id_rs_ex | id_rs_mem | (id_rs_wb & (RF_BYPASS == 0));
    assign h_rt  = id_rt_ex | id_rt_mem | (id_rt_wb & (RF_BYPASS == 0));
    assign fwd_a = FWD_IDEX;
    assign fwd_b = FWD_IDEX;
`endif

    assign hz    = id_valid & ((id_uses_rs & h_rs) | (id_uses_rt & h_rt));
    assign stall = hz & ~branch_taken;

    assign pc_hold     = stall;
    assign ifid_hold   = stall;
    assign idex_bubble = stall;
    assign flush_ifid  = branch_taken;
    assign flush_idex  = branch_taken;
    assign flush_exmem = branch_taken;

    // Not every slot field feeds logic in every build; collect them here.
    logic unused_fields;
    assign unused_fields = ^{ex_q, mem_q, wb_q, id_rs_mem, id_rs_wb, id_rt_mem, id_rt_wb,
                             (RF_BYPASS == 0)};

    // Advance the in-flight scoreboard; stalls and flushes insert empty slots.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= (stall | branch_taken) ? '0 : id_slot;
            mem_q <= branch_taken ? '0 : ex_q;
            wb_q  <= mem_q;
        end
    end

    // Saturating debug counters of held cycles and taken branches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && stall_count != CNT_MAX)
                stall_count <= stall_count + CNT_WIDTH'(1);
            if (branch_taken && flush_count != CNT_MAX)
                flush_count <= flush_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb/tb_pipeline_hazard_unit.sv - directed table-driven bench for pipeline_hazard_unit
module tb_pipeline_hazard_unit;

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       rw;
        logic       mr;
        logic [4:0] wa;
        logic       br;
        logic       st;
        logic       fl;
        logic [1:0] fa;
        logic [1:0] fb;
        int         sc;
        int         fc;
    } vec_t;

`ifdef HAZARD_FORWARD_EN
    localparam int SPP    = 1;
    localparam int TBL_SC = 1;
`else
    localparam int SPP    = 2;
    localparam int TBL_SC = 3;
`endif

    logic       clk;
    logic       reset_n;
    logic       id_valid;
    logic [4:0] id_rs_addr;
    logic [4:0] id_rt_addr;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_reg_write;
    logic       id_mem_read;
    logic [4:0] id_w_addr;
    logic       branch_taken;

    logic        pc_hold, ifid_hold, idex_bubble;
    logic        flush_ifid, flush_idex, flush_exmem;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count, flush_count;

    logic        s_pc_hold, s_ifid_hold, s_idex_bubble;
    logic        s_flush_ifid, s_flush_idex, s_flush_exmem;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_count, s_flush_count;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl[$];

    pipeline_hazard_unit dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_w_addr(id_w_addr), .branch_taken(branch_taken),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_hazard_unit #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_w_addr(id_w_addr), .branch_taken(branch_taken),
        .pc_hold(s_pc_hold), .ifid_hold(s_ifid_hold), .idex_bubble(s_idex_bubble),
        .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex), .flush_exmem(s_flush_exmem),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_v(input logic v, input int rs, input int rt, input logic urs,
                         input logic urt, input logic rw, input logic mr, input int wa,
                         input logic br, input logic st, input logic fl,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input int sc, input int fc);
        vec_t t;
        t.v = v; t.rs = 5'(rs); t.rt = 5'(rt); t.urs = urs; t.urt = urt;
        t.rw = rw; t.mr = mr; t.wa = 5'(wa); t.br = br;
        t.st = st; t.fl = fl; t.fa = fa; t.fb = fb; t.sc = sc; t.fc = fc;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic v, input int rs, input int rt, input logic urs,
                         input logic urt, input logic rw, input logic mr, input int wa,
                         input logic br);
        id_valid = v; id_rs_addr = 5'(rs); id_rt_addr = 5'(rt);
        id_uses_rs = urs; id_uses_rt = urt; id_reg_write = rw;
        id_mem_read = mr; id_w_addr = 5'(wa); branch_taken = br;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " pc_hold"}, 32'(pc_hold), 0);
        chk({tag, " ifid_hold"}, 32'(ifid_hold), 0);
        chk({tag, " idex_bubble"}, 32'(idex_bubble), 0);
        chk({tag, " flush_ifid"}, 32'(flush_ifid), 0);
        chk({tag, " flush_idex"}, 32'(flush_idex), 0);
        chk({tag, " flush_exmem"}, 32'(flush_exmem), 0);
        chk({tag, " fwd_a"}, 32'(fwd_a), 0);
        chk({tag, " fwd_b"}, 32'(fwd_b), 0);
        chk({tag, " stall_count"}, 32'(stall_count), 0);
        chk({tag, " flush_count"}, 32'(flush_count), 0);
        chk({tag, " sat stall_count"}, 32'(s_stall_count), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef HAZARD_FORWARD_EN
        // v rs rt urs urt rw mr wa br | st fl fa fb sc fc
        add_v(1, 0, 0, 0, 0, 1, 1, 2, 0,  0, 0, 2'b00, 2'b00, 0, 0); // lw $2
        add_v(1, 2, 2, 1, 1, 1, 0, 7, 0,  1, 0, 2'b00, 2'b00, 0, 0); // load-use stall
        add_v(1, 2, 2, 1, 1, 1, 0, 7, 0,  0, 0, 2'b00, 2'b00, 1, 0); // one cycle only
        add_v(1, 0, 0, 0, 0, 1, 0, 3, 0,  0, 0, 2'b01, 2'b01, 1, 0); // load data from WB
        add_v(1, 0, 0, 0, 0, 1, 0, 3, 0,  0, 0, 2'b00, 2'b00, 1, 0); // add $3 again
        add_v(1, 3, 3, 1, 1, 1, 0, 8, 0,  0, 0, 2'b00, 2'b00, 1, 0); // user of $3
        add_v(1, 0, 0, 1, 1, 1, 0, 0, 0,  0, 0, 2'b10, 2'b10, 1, 0); // MEM beats WB
        add_v(1, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 2'b00, 2'b00, 1, 0); // lw $0
        add_v(1, 0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 1, 0); // read $0: no stall
        add_v(1, 0, 0, 0, 0, 1, 1, 2, 0,  0, 0, 2'b00, 2'b00, 1, 0); // lw $2
        add_v(1, 2, 0, 1, 0, 1, 0, 3, 1,  0, 1, 2'b00, 2'b00, 1, 0); // branch over stall
        add_v(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 1, 1);
`else
        // v rs rt urs urt rw mr wa br | st fl fa fb sc fc
        add_v(1, 0, 0, 0, 0, 1, 0, 4, 0,  0, 0, 2'b00, 2'b00, 0, 0); // add $4
        add_v(1, 4, 0, 1, 0, 1, 0, 5, 0,  1, 0, 2'b00, 2'b00, 0, 0); // producer in EX
        add_v(1, 4, 0, 1, 0, 1, 0, 5, 0,  1, 0, 2'b00, 2'b00, 1, 0); // producer in MEM
        add_v(1, 4, 0, 1, 0, 1, 0, 5, 0,  0, 0, 2'b00, 2'b00, 2, 0); // WB bypassed
        add_v(1, 0, 0, 1, 1, 1, 0, 0, 0,  0, 0, 2'b00, 2'b00, 2, 0); // $0 reader/writer
        add_v(1, 0, 0, 1, 1, 1, 0, 0, 0,  0, 0, 2'b00, 2'b00, 2, 0); // $0 writer in EX
        add_v(1, 0, 5, 1, 1, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 2, 0); // $5 only in WB
        add_v(1, 0, 0, 0, 0, 1, 1, 2, 0,  0, 0, 2'b00, 2'b00, 2, 0); // lw $2
        add_v(1, 2, 7, 1, 1, 1, 0, 3, 1,  0, 1, 2'b00, 2'b00, 2, 0); // branch over stall
        add_v(1, 2, 7, 1, 1, 1, 0, 3, 0,  0, 0, 2'b00, 2'b00, 2, 1); // load was flushed
        add_v(1, 0, 3, 0, 1, 0, 0, 0, 0,  1, 0, 2'b00, 2'b00, 2, 1); // rt hazard
        add_v(0, 0, 3, 0, 1, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 3, 1); // id_valid low
        add_v(1, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 3, 1); // no operand used
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, int'(tbl[i].rs), int'(tbl[i].rt), tbl[i].urs, tbl[i].urt,
                  tbl[i].rw, tbl[i].mr, int'(tbl[i].wa), tbl[i].br);
            @(negedge clk);
            chk($sformatf("v%0d pc_hold", i), 32'(pc_hold), 32'(tbl[i].st));
            chk($sformatf("v%0d ifid_hold", i), 32'(ifid_hold), 32'(tbl[i].st));
            chk($sformatf("v%0d idex_bubble", i), 32'(idex_bubble), 32'(tbl[i].st));
            chk($sformatf("v%0d flush_ifid", i), 32'(flush_ifid), 32'(tbl[i].fl));
            chk($sformatf("v%0d flush_idex", i), 32'(flush_idex), 32'(tbl[i].fl));
            chk($sformatf("v%0d flush_exmem", i), 32'(flush_exmem), 32'(tbl[i].fl));
            chk($sformatf("v%0d fwd_a", i), 32'(fwd_a), 32'(tbl[i].fa));
            chk($sformatf("v%0d fwd_b", i), 32'(fwd_b), 32'(tbl[i].fb));
            chk($sformatf("v%0d stall_count", i), 32'(stall_count), 32'(tbl[i].sc));
            chk($sformatf("v%0d flush_count", i), 32'(flush_count), 32'(tbl[i].fc));
            @(posedge clk);
            #1;
        end

        // Five load/use pairs: the narrow counter must pin at 3.
        for (int p = 0; p < 5; p++) begin
            drive(1, 0, 0, 0, 0, 1, 1, 9, 0);
            @(negedge clk);
            chk($sformatf("pair%0d producer pc_hold", p), 32'(pc_hold), 0);
            @(posedge clk);
            #1;
            drive(1, 9, 0, 1, 0, 0, 0, 0, 0);
            for (int k = 0; k <= SPP; k++) begin
                @(negedge clk);
                chk($sformatf("pair%0d cyc%0d pc_hold", p, k), 32'(pc_hold),
                    (k < SPP) ? 32'd1 : 32'd0);
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        chk("stall_count after pairs", 32'(stall_count), 32'(TBL_SC + 5 * SPP));
        chk("sat stall_count", 32'(s_stall_count), 3);
        chk("sat flush_count", 32'(s_flush_count), 1);
        chk("flush_count after pairs", 32'(flush_count), 1);
        @(posedge clk);
        #1;

        // Reset dropped in the middle of a stall clears everything at once.
        drive(1, 0, 0, 0, 0, 1, 1, 9, 0);
        @(posedge clk);
        #1;
        drive(1, 9, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre-reset pc_hold", 32'(pc_hold), 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk_idle("mid-stall reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("post-reset pc_hold", 32'(pc_hold), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post-reset cycle2 pc_hold", 32'(pc_hold), 0);
        chk("post-reset stall_count", 32'(stall_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
